plate_judge_vote: RTL and testbench

- Parametrised successor to the plate-character judge. Sits between the template-matching stage (per-character best index plus difference score) and the result register/CPU interface.
- Each frame it checks match quality and tracks run-length agreement across consecutive frames. It emits a confirmed plate once agreement is reached, or a fail pulse after a frame budget expires.
- Character count, index width and score width are parameters; timeout and fail reporting are additions over the previous judge.

---
 rtl/plate_judge_vote.sv | 107 ++++++++++
 tb/tb_plate_judge_vote.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plate_judge_vote.sv
// rtl/plate_judge_vote.sv - multi-frame plate vote with confirm/timeout; JUDGE_DIFF_SUM_EN selects the sum-of-diffs quality check
module plate_judge_vote #(
    parameter int NCHAR  = 7,
    parameter int IDX_W  = 4,
    parameter int DIFF_W = 16,
    parameter int CONT_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DIFF_W-1:0]       max_diff,
    input  logic [CONT_W-1:0]       min_continue,
    input  logic [CNT_W-1:0]        min_counter,
    input  logic [NCHAR*IDX_W-1:0]  char_index_c,
    input  logic [NCHAR*DIFF_W-1:0] char_diff_c,
    input  logic                    char_valid_c,
    output logic [NCHAR*IDX_W-1:0]  char_index_co,
    output logic                    char_valid_co,
    output logic                    char_fail_co,
    output logic [CONT_W-1:0]       run_cnt
);

    logic [NCHAR*IDX_W-1:0] cand;
    logic                   cand_valid;
    logic [CNT_W-1:0]       frame_cnt;

    logic                   good;
    logic [CONT_W-1:0]      eff_cont;
    logic [CONT_W-1:0]      run_next;
    logic [CNT_W-1:0]       frame_next;
    logic                   confirm;
    logic                   timeout;

`ifdef JUDGE_DIFF_SUM_EN
    localparam int SUM_W = DIFF_W + $clog2(NCHAR) + 1;
    logic [SUM_W-1:0] diff_sum;
    logic [SUM_W-1:0] sum_limit;

    always_comb begin
        diff_sum = '0;
        for (int i = 0; i < NCHAR; i++) begin
            diff_sum = diff_sum + SUM_W'(char_diff_c[i*DIFF_W +: DIFF_W]);
        end
        sum_limit = SUM_W'(max_diff) * SUM_W'(NCHAR);
        good      = (diff_sum <= sum_limit);
    end
`else
    always_comb begin
        good = 1'b1;
        for (int i = 0; i < NCHAR; i++) begin
            if (char_diff_c[i*DIFF_W +: DIFF_W] > max_diff) begin
                good = 1'b0;
            end
        end
    end
`endif

    always_comb begin
        eff_cont   = (min_continue == '0) ? CONT_W'(1) : min_continue;
        frame_next = (frame_cnt == '1) ? frame_cnt : frame_cnt + 1'b1;
        if (!good) begin
            run_next = '0;
        end else if (cand_valid && (char_index_c == cand)) begin
            run_next = (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;
        end else begin
            run_next = CONT_W'(1);
        end
        confirm = good && (run_next == eff_cont);
        timeout = !confirm && (min_counter != '0) && (frame_next >= min_counter);
    end

    // Confirm takes priority over timeout; the candidate survives a confirm so a repeat needs a fresh run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand          <= '0;
            cand_valid    <= 1'b0;
            frame_cnt     <= '0;
            run_cnt       <= '0;
            char_index_co <= '0;
            char_valid_co <= 1'b0;
            char_fail_co  <= 1'b0;
        end else begin
            char_valid_co <= 1'b0;
            char_fail_co  <= 1'b0;
            if (char_valid_c) begin
                if (good) begin
                    cand       <= char_index_c;
                    cand_valid <= 1'b1;
                end
                frame_cnt <= frame_next;
                run_cnt   <= run_next;
                if (confirm) begin
                    char_index_co <= char_index_c;
                    char_valid_co <= 1'b1;
                    run_cnt       <= '0;
                    frame_cnt     <= '0;
                end else if (timeout) begin
                    char_fail_co <= 1'b1;
                    frame_cnt    <= '0;
                    run_cnt      <= '0;
                    cand_valid   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_plate_judge_vote.sv
// tb/tb_plate_judge_vote.sv - self-checking bench for plate_judge_vote with a frame-level reference model
module tb_plate_judge_vote;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  max_diff = '0;
    logic [3:0]   min_continue = '0;
    logic [7:0]   min_counter = '0;
    logic [27:0]  char_index_c = '0;
    logic [111:0] char_diff_c = '0;
    logic         char_valid_c = 1'b0;
    logic [27:0]  char_index_co;
    logic         char_valid_co;
    logic         char_fail_co;
    logic [3:0]   run_cnt;

    int n_checks = 0;
    int n_fail = 0;

    logic [27:0] m_cand;
    bit          m_cvalid;
    int          m_run;
    int          m_frames;
    logic [27:0] m_index;
    bit          exp_valid;
    bit          exp_fail;
    int          exp_run;

    localparam logic [27:0] PLATE_A = 28'h43210aa;
    localparam logic [27:0] PLATE_B = 28'h53210aa;

    plate_judge_vote dut (
        .clk(clk), .rst_n(rst_n), .max_diff(max_diff), .min_continue(min_continue),
        .min_counter(min_counter), .char_index_c(char_index_c), .char_diff_c(char_diff_c),
        .char_valid_c(char_valid_c), .char_index_co(char_index_co), .char_valid_co(char_valid_co),
        .char_fail_co(char_fail_co), .run_cnt(run_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [111:0] flat_diff(input int v);
        logic [111:0] r;
        for (int i = 0; i < 7; i++) r[i*16 +: 16] = 16'(v);
        return r;
    endfunction

    task automatic model_clear();
        m_cand = '0; m_cvalid = 0; m_run = 0; m_frames = 0; m_index = '0;
        exp_valid = 0; exp_fail = 0; exp_run = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        char_valid_c = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_cfg(input int md, input int mc, input int mn);
        max_diff = 16'(md); min_continue = 4'(mc); min_counter = 8'(mn);
    endtask

    // Drives one frame starting from a negedge; on return the expected post-edge outputs are in exp_*.
    task automatic send_frame(input logic [27:0] idx, input logic [111:0] dif);
        bit good;
        int s;
        int eff;
        char_index_c = idx;
        char_diff_c  = dif;
        char_valid_c = 1'b1;
`ifdef JUDGE_DIFF_SUM_EN
        s = 0;
        for (int i = 0; i < 7; i++) s += int'(dif[i*16 +: 16]);
        good = (s <= int'(max_diff) * 7);
`else
        good = 1;
        for (int i = 0; i < 7; i++) if (dif[i*16 +: 16] > max_diff) good = 0;
`endif
        m_frames = (m_frames >= 255) ? 255 : m_frames + 1;
        eff = (min_continue == 0) ? 1 : int'(min_continue);
        if (!good) m_run = 0;
        else if (m_cvalid && idx == m_cand) m_run = (m_run >= 15) ? 15 : m_run + 1;
        else begin
            m_cand = idx; m_cvalid = 1; m_run = 1;
        end
        exp_valid = good && (m_run == eff);
        exp_fail  = 0;
        if (exp_valid) begin
            m_index = idx; m_run = 0; m_frames = 0;
        end else if (min_counter != 0 && m_frames >= int'(min_counter)) begin
            exp_fail = 1; m_frames = 0; m_run = 0; m_cvalid = 0;
        end
        exp_run = m_run;
        @(posedge clk);
        @(negedge clk);
        char_valid_c = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        set_cfg(30, 1, 0);
        @(negedge clk);
        char_index_c = PLATE_A; char_diff_c = flat_diff(0); char_valid_c = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({char_index_co, char_valid_co, char_fail_co, run_cnt} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", {char_index_co, char_valid_co, char_fail_co, run_cnt});
        end
        char_valid_c = 1'b0;
        rst_n = 1'b1;
        model_clear();
        idle_cycle();
        n_checks++;
        if ({char_valid_co, char_fail_co} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_exit_pulse: got %b want 00", {char_valid_co, char_fail_co});
        end
    endtask

    task automatic test_basic_confirm();
        do_reset();
        set_cfg(30, 2, 10);
        send_frame(PLATE_A, flat_diff(16'h10));
        n_checks++;
        if (run_cnt !== 4'd1 || char_valid_co !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_first: run %0d valid %b want run 1 valid 0", run_cnt, char_valid_co);
        end
        send_frame(PLATE_A, flat_diff(16'h10));
        n_checks++;
        if (char_valid_co !== 1'b1 || char_index_co !== 28'h43210aa || run_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_confirm: valid %b index %h run %0d want 1 43210aa 0", char_valid_co, char_index_co, run_cnt);
        end
        idle_cycle();
        n_checks++;
        if (char_valid_co !== 1'b0 || char_index_co !== 28'h43210aa) begin
            n_fail++;
            $display("FAIL basic_pulse_width: valid %b index %h want 0 43210aa", char_valid_co, char_index_co);
        end
    endtask

    task automatic test_candidate_change();
        logic [27:0] seq [4];
        int          runs [4];
        bit          vals [4];
        seq = '{PLATE_A, PLATE_B, PLATE_A, PLATE_A};
        runs = '{1, 1, 1, 0};
        vals = '{0, 0, 0, 1};
        do_reset();
        set_cfg(30, 2, 10);
        for (int k = 0; k < 4; k++) begin
            send_frame(seq[k], flat_diff(16'h10));
            n_checks++;
            if (run_cnt !== 4'(runs[k]) || char_valid_co !== vals[k]) begin
                n_fail++;
                $display("FAIL cand_change frame %0d: run %0d valid %b want run %0d valid %0d", k, run_cnt, char_valid_co, runs[k], vals[k]);
            end
        end
    endtask

    task automatic test_bad_frame();
        logic [111:0] bad;
        int runs [3];
        bit seen;
        runs = '{1, 0, 1};
        bad = flat_diff(16'h10);
        bad[3*16 +: 16] = 16'h50;
        do_reset();
        set_cfg(30, 2, 10);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            send_frame(PLATE_A, (k == 1) ? bad : flat_diff(16'h10));
            if (char_valid_co) seen = 1;
            n_checks++;
            if (run_cnt !== 4'(runs[k])) begin
                n_fail++;
                $display("FAIL bad_frame_run frame %0d: got %0d want %0d", k, run_cnt, runs[k]);
            end
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL bad_frame_noconfirm: got confirm want none");
        end
    endtask

    task automatic test_timeout();
        int fails;
        bit seen_valid;
        do_reset();
        set_cfg(30, 2, 10);
        fails = 0; seen_valid = 0;
        for (int k = 1; k <= 10; k++) begin
            send_frame(PLATE_A, flat_diff(16'h50));
            if (char_valid_co) seen_valid = 1;
            if (char_fail_co) fails++;
            n_checks++;
            if (char_fail_co !== (k == 10)) begin
                n_fail++;
                $display("FAIL timeout_frame %0d: fail %b want %0d", k, char_fail_co, (k == 10));
            end
        end
        idle_cycle();
        n_checks++;
        if (char_fail_co !== 1'b0 || fails != 1 || seen_valid || char_index_co !== 28'd0) begin
            n_fail++;
            $display("FAIL timeout_once: fail %b count %0d valid_seen %0d index %h want 0 1 0 0", char_fail_co, fails, seen_valid, char_index_co);
        end
    endtask

    task automatic test_min_continue_zero();
        do_reset();
        set_cfg(30, 0, 10);
        send_frame(PLATE_A, flat_diff(5));
        n_checks++;
        if (char_valid_co !== 1'b1 || char_index_co !== PLATE_A) begin
            n_fail++;
            $display("FAIL mc0_first: valid %b index %h want 1 %h", char_valid_co, char_index_co, PLATE_A);
        end
        send_frame(PLATE_B, flat_diff(30));
        n_checks++;
        if (char_valid_co !== 1'b1 || char_index_co !== PLATE_B) begin
            n_fail++;
            $display("FAIL mc0_second: valid %b index %h want 1 %h", char_valid_co, char_index_co, PLATE_B);
        end
    endtask

    task automatic test_no_timeout_saturation();
        int fails;
        do_reset();
        set_cfg(30, 2, 0);
        fails = 0;
        for (int k = 0; k < 300; k++) begin
            send_frame(PLATE_A, flat_diff(16'h50));
            if (char_fail_co) fails++;
        end
        n_checks++;
        if (fails != 0) begin
            n_fail++;
            $display("FAIL no_timeout: got %0d fail pulses want 0", fails);
        end
        min_counter = 8'd255;
        send_frame(PLATE_A, flat_diff(16'h50));
        n_checks++;
        if (char_fail_co !== 1'b1) begin
            n_fail++;
            $display("FAIL counter_saturation: fail %b want 1", char_fail_co);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        set_cfg(30, 2, 10);
        send_frame(PLATE_A, flat_diff(16'h10));
        rst_n = 1'b0;
        char_index_c = PLATE_A; char_valid_c = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({char_index_co, char_valid_co, char_fail_co, run_cnt} !== 34'd0) begin
            n_fail++;
            $display("FAIL midrun_reset_outputs: got %h want 0", {char_index_co, char_valid_co, char_fail_co, run_cnt});
        end
        char_valid_c = 1'b0;
        rst_n = 1'b1;
        model_clear();
        send_frame(PLATE_A, flat_diff(16'h10));
        n_checks++;
        if (char_valid_co !== 1'b0 || run_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL midrun_first: valid %b run %0d want 0 1", char_valid_co, run_cnt);
        end
        send_frame(PLATE_A, flat_diff(16'h10));
        n_checks++;
        if (char_valid_co !== 1'b1 || char_index_co !== PLATE_A) begin
            n_fail++;
            $display("FAIL midrun_second: valid %b index %h want 1 %h", char_valid_co, char_index_co, PLATE_A);
        end
    endtask

    task automatic test_random();
        logic [27:0]  plates [3];
        logic [27:0]  idx;
        logic [111:0] dif;
        int md;
        plates = '{PLATE_A, PLATE_B, 28'h1234567};
        do_reset();
        for (int f = 0; f < 400; f++) begin
            if (f % 50 == 0) set_cfg($urandom_range(10, 60), $urandom_range(0, 3), $urandom_range(0, 12));
            md = int'(max_diff);
            idx = plates[($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 2)];
            for (int i = 0; i < 7; i++) dif[i*16 +: 16] = 16'($urandom_range(0, md));
            if ($urandom_range(0, 9) < 3) dif[$urandom_range(0, 6)*16 +: 16] = 16'($urandom_range(md + 1, 400));
            send_frame(idx, dif);
            n_checks++;
            if (char_valid_co !== exp_valid || char_fail_co !== exp_fail || char_index_co !== m_index || run_cnt !== 4'(exp_run)) begin
                n_fail++;
                $display("FAIL random frame %0d: valid %b fail %b index %h run %0d want %0d %0d %h %0d",
                         f, char_valid_co, char_fail_co, char_index_co, run_cnt, exp_valid, exp_fail, m_index, exp_run);
            end
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle();
                n_checks++;
                if (char_valid_co !== 1'b0 || char_fail_co !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random_idle frame %0d: valid %b fail %b want 0 0", f, char_valid_co, char_fail_co);
                end
            end
        end
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        test_reset();
        test_basic_confirm();
        test_candidate_change();
        test_bad_frame();
        test_timeout();
        test_min_continue_zero();
        test_no_timeout_saturation();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
